alu_seq: RTL and testbench

- 8-bit registered ALU sitting directly downstream of the B-operand select mux.
- Consumes register A and the selected B operand (B reg / immediate / zero / data-memory byte), produces registered result and status flags for writeback and branch logic.
- Single-cycle ops complete in one clock; optional multiply runs as an 8-step shift-add sequence with busy/done handshake.

---
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: 8-bit registered ALU fed by register A and the B-operand mux.
// Latency: single-cycle ops -> result/flags/done one edge after start; MUL -> done 8 edges after start.
// Backpressure: none; start is sampled only in IDLE, starts while busy are dropped (no queueing).
//
// Ports: clk, reset (sync, active-high), start, op[3:0], a, b -> result, flags {Z,N,C,V}, busy, done.
// Optional feature: define ALU_MUL_EN to build the shift-add multiplier (op 1010).
// Without it, op 1010 is treated like a reserved opcode and busy is tied low.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_PASS = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

  // a == 0x7F pattern (largest positive value) for INC overflow
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // Single-cycle datapath
  logic [WIDTH:0]   sum, diff, inc;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v, alu_ok;
  logic [3:0]       alu_f;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    inc    = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_ok = 1'b1;
    case (op)
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];  // borrow: a < b unsigned
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOT:  alu_r = ~a;
      OP_SHL: begin
        alu_r = {a[WIDTH-2:0], 1'b0};
        alu_c = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, a[WIDTH-1:1]};
        alu_c = a[0];
      end
      OP_INC: begin
        alu_r = inc[WIDTH-1:0];
        alu_c = inc[WIDTH];
        alu_v = (a == MAX_POS);
      end
      OP_PASS: alu_r = b;
      // reserved codes (and MUL, which is handled by the sequencer) load nothing
      default: alu_ok = 1'b0;
    endcase
    alu_f = {(alu_r == '0), alu_r[WIDTH-1], alu_c, alu_v};
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]         state;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb acc_nxt = acc + (mplier[0] ? mcand : '0);

  assign busy = (state == ST_MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              cnt    <= '0;
              state  <= ST_MUL;
            end else begin
              done <= 1'b1;
              if (alu_ok) begin
                result <= alu_r;
                flags  <= alu_f;
              end
            end
          end
        end
        default: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // last step: acc_nxt holds the full product
            result <= acc_nxt[WIDTH-1:0];
            flags  <= {(acc_nxt[WIDTH-1:0] == '0), acc_nxt[WIDTH-1],
                       (acc_nxt[2*WIDTH-1:WIDTH] != '0), 1'b0};
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
    end else begin
      done <= start;
      if (start && alu_ok) begin
        result <= alu_r;
        flags  <= alu_f;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized + directed self-checking bench for alu_seq against a behavioural model.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
// Works with and without ALU_MUL_EN (multiply expectations follow the macro).
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] op;
  logic [7:0] a, b;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy, done;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_r;
  logic [3:0] exp_f;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int sgn(input logic [7:0] x);
    return (x > 127) ? int'(x) - 256 : int'(x);
  endfunction

  // Returns {valid, r[7:0], Z, N, C, V}; valid=0 means registers must hold.
  function automatic logic [12:0] ref_alu(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int   val, s;
    logic c, v, ok;
    logic [7:0] r;
    c = 1'b0; v = 1'b0; ok = 1'b1; val = 0;
    case (o)
      4'd0: begin val = x + y; c = (val > 255); s = sgn(x) + sgn(y); v = (s > 127) || (s < -128); end
      4'd1: begin val = int'(x) - int'(y) + 256; c = (x < y); s = sgn(x) - sgn(y); v = (s > 127) || (s < -128); end
      4'd2: val = x & y;
      4'd3: val = x | y;
      4'd4: val = x ^ y;
      4'd5: val = 255 - x;
      4'd6: begin val = x * 2; c = (x >= 128); end
      4'd7: begin val = x / 2; c = (x % 2 == 1); end
      4'd8: begin val = x + 1; c = (x == 255); v = (x == 127); end
      4'd9: val = y;
`ifdef ALU_MUL_EN
      4'd10: begin val = x * y; c = (val > 255); end
`endif
      default: ok = 1'b0;
    endcase
    r = 8'(val % 256);
    return {ok, r, (r == 8'd0), (r >= 8'd128), c, v};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_r = 8'h00; exp_f = 4'b0000;
    check("rst_result", result, 8'h00);
    check("rst_flags", flags, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_tail(input logic [12:0] m);
    @(posedge clk); #1;
    start = 1'b0;
    check("mul_busy0", busy, 1'b1);
    check("mul_done0", done, 1'b0);
    // edges 1..7 after start: still busy; random ignored starts and operand changes
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      check("mul_busy", busy, 1'b1);
      check("mul_done", done, 1'b0);
      check("mul_hold", result, exp_r);
    end
    @(posedge clk); #1;
    exp_r = m[11:4]; exp_f = m[3:0];
    check("mul_done8", done, 1'b1);
    check("mul_busy8", busy, 1'b0);
    check("mul_result", result, exp_r);
    check("mul_flags", flags, exp_f);
  endtask
`endif

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [12:0] m;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    m = ref_alu(o, x, y);
`ifdef ALU_MUL_EN
    if (o == 4'd10) begin
      mul_tail(m);
      return;
    end
`endif
    @(posedge clk); #1;
    start = 1'b0;
    if (m[12]) begin
      exp_r = m[11:4]; exp_f = m[3:0];
    end
    check("op_done", done, 1'b1);
    check("op_result", result, exp_r);
    check("op_flags", flags, exp_f);
    check("op_busy", busy, 1'b0);
  endtask

  task automatic directed(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] want_r, input logic [3:0] want_f);
    run_op(o, x, y);
    check("dir_result", result, want_r);
    check("dir_flags", flags, want_f);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom_range(0, 15));
    a = 8'($urandom); b = 8'($urandom);
    @(posedge clk); #1;
    check("idle_done", done, 1'b0);
    check("idle_result", result, exp_r);
    check("idle_flags", flags, exp_f);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0;
    exp_r = 8'h00; exp_f = 4'b0000;
    repeat (2) @(posedge clk);
    do_reset();
    idle_cycle();

    // flags are {Z,N,C,V}
    directed(4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101);
    directed(4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010);
    directed(4'd1, 8'h03, 8'h05, 8'hFE, 4'b0110);
    directed(4'd1, 8'h05, 8'h05, 8'h00, 4'b1000);
    directed(4'd6, 8'h81, 8'h00, 8'h02, 4'b0010);
    directed(4'd7, 8'h81, 8'h00, 8'h40, 4'b0010);
    directed(4'd8, 8'h7F, 8'h00, 8'h80, 4'b0101);
    directed(4'd9, 8'h55, 8'h00, 8'h00, 4'b1000);
    idle_cycle();
    directed(4'd0, 8'h40, 8'h02, 8'h42, 4'b0000);
`ifdef ALU_MUL_EN
    directed(4'd10, 8'h0C, 8'h0A, 8'h78, 4'b0000);
    directed(4'd10, 8'h20, 8'h10, 8'h00, 4'b1010);
    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 4'd10; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_busy", busy, 1'b1);
    repeat (3) @(posedge clk);
    do_reset();
    directed(4'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0100);
`else
    directed(4'd10, 8'h0C, 8'h0A, 8'h42, 4'b0000);
    check("nomul_busy", busy, 1'b0);
`endif
    directed(4'd12, 8'h12, 8'h34, exp_r, exp_f);
    idle_cycle();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      else run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end

    do_reset();
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
